// File: rtl/cdb_broadcaster_if.sv
// Bundle of the execution-unit completion handshakes and the registered CDB
// broadcast. The producer/consumer side of the bench takes master; the broadcaster takes slave.
interface cdb_broadcaster_if #(
    parameter int NUM_SRC = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5
);
    localparam int SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC*TAG_W-1:0]  src_tag;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC*REG_W-1:0]  src_rd;

    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic [REG_W-1:0]          cdb_rd;
    logic [SRC_W-1:0]          cdb_src;

    modport master (
        output src_valid, src_tag, src_data, src_rd,
        input  src_ready,
        input  cdb_valid, cdb_tag, cdb_data, cdb_rd, cdb_src
    );

    modport slave (
        input  src_valid, src_tag, src_data, src_rd,
        output src_ready,
        output cdb_valid, cdb_tag, cdb_data, cdb_rd, cdb_src
    );
endinterface

// File: rtl/cdb_broadcaster.sv
// Common data bus producer: one holding register per execution unit, round-robin
// arbitration among full entries, and a registered single-result broadcast per cycle.
module cdb_broadcaster #(
    parameter int NUM_SRC = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    cdb_broadcaster_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] hold_v_q, hold_v_d;
    logic [TAG_W-1:0]   hold_tag_q  [NUM_SRC];
    logic [TAG_W-1:0]   hold_tag_d  [NUM_SRC];
    logic [DATA_W-1:0]  hold_data_q [NUM_SRC];
    logic [DATA_W-1:0]  hold_data_d [NUM_SRC];
    logic [REG_W-1:0]   hold_rd_q   [NUM_SRC];
    logic [REG_W-1:0]   hold_rd_d   [NUM_SRC];

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
    logic [REG_W-1:0]   cdb_rd_q, cdb_rd_d;
    logic [PTR_W-1:0]   cdb_src_q, cdb_src_d;

    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] ready;
    logic [NUM_SRC-1:0] accept;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_found;
    logic [PTR_W-1:0]   idx;
    int                 sum;

    // Round-robin search starting at rr_ptr; a flush suppresses any grant.
    always_comb begin
        // NOTE: every variable gets a default first and is written with blocking
        // assignments, so the block is pure combinational logic with no latches.
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        sum       = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            sum = int'(rr_ptr_q) + k;
            if (sum >= NUM_SRC) begin
                sum = sum - NUM_SRC;
            end
            idx = PTR_W'(sum);
            if (!gnt_found && hold_v_q[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
        if (flush) begin
            gnt_found = 1'b0;
        end
        grant = '0;
        if (gnt_found) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    // A granted entry may be refilled on the same edge it drains.
    assign ready  = flush ? '0 : (~hold_v_q | grant);
    assign accept = bus.src_valid & ready;

    always_comb begin
        hold_v_d    = flush ? '0 : ((hold_v_q & ~grant) | accept);
        hold_tag_d  = hold_tag_q;
        hold_data_d = hold_data_q;
        hold_rd_d   = hold_rd_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (accept[i]) begin
                hold_tag_d[i]  = bus.src_tag[i*TAG_W +: TAG_W];
                hold_data_d[i] = bus.src_data[i*DATA_W +: DATA_W];
                hold_rd_d[i]   = bus.src_rd[i*REG_W +: REG_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = gnt_found;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_rd_d    = cdb_rd_q;
        cdb_src_d   = cdb_src_q;
        if (gnt_found) begin
            rr_ptr_d   = (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + PTR_W'(1);
            cdb_tag_d  = hold_tag_q[gnt_idx];
            cdb_data_d = hold_data_q[gnt_idx];
            cdb_rd_d   = hold_rd_q[gnt_idx];
            cdb_src_d  = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_v_q    <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_rd_q    <= '0;
            cdb_src_q   <= '0;
        end else begin
            hold_v_q    <= hold_v_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_rd_q    <= cdb_rd_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    // NOTE: the payload storage has no reset; hold_v qualifies every read of it.
    always_ff @(posedge clk) begin
        hold_tag_q  <= hold_tag_d;
        hold_data_q <= hold_data_d;
        hold_rd_q   <= hold_rd_d;
    end

    assign bus.src_ready = ready & {NUM_SRC{rst}};
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_rd    = cdb_rd_q;
    assign bus.cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: directed vector table, async-reset
// sequence, and randomized traffic against a slot/queue reference model.
module tb_cdb_broadcaster;
    localparam int N  = 4;
    localparam int TW = 6;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int SW = 2;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    cdb_broadcaster_if #(.NUM_SRC(N), .TAG_W(TW), .DATA_W(DW), .REG_W(RW)) bus ();

    cdb_broadcaster #(.NUM_SRC(N), .TAG_W(TW), .DATA_W(DW), .REG_W(RW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Input drive state
    logic [N-1:0]  drv_valid;
    logic [TW-1:0] drv_tag  [N];
    logic [DW-1:0] drv_data [N];
    logic [RW-1:0] drv_rd   [N];
    logic [N-1:0]  last_ready;

    // Reference model: one result slot per source plus a rotating priority pointer
    logic          m_hv   [N];
    logic [TW-1:0] m_tag  [N];
    logic [DW-1:0] m_data [N];
    logic [RW-1:0] m_rd   [N];
    int            m_ptr;
    logic          m_cv;
    logic [TW-1:0] m_ctag;
    logic [DW-1:0] m_cdata;
    logic [RW-1:0] m_crd;
    logic [SW-1:0] m_csrc;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
        m_ptr = 0; m_cv = 1'b0; m_ctag = '0; m_cdata = '0; m_crd = '0; m_csrc = '0;
    endtask

    function automatic int model_grant();
        int g = -1;
        if (flush) return -1;
        for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (g < 0 && m_hv[j]) g = j;
        end
        return g;
    endfunction

    task automatic apply_inputs();
        bus.src_valid = drv_valid;
        for (int i = 0; i < N; i++) begin
            bus.src_tag[i*TW +: TW]  = drv_tag[i];
            bus.src_data[i*DW +: DW] = drv_data[i];
            bus.src_rd[i*RW +: RW]   = drv_rd[i];
        end
    endtask

    // One clock: drive, check src_ready mid-cycle, advance model, check CDB after the edge.
    task automatic cycle(input string name);
        int g;
        logic [N-1:0] exp_rdy;
        apply_inputs();
        @(negedge clk);
        g = model_grant();
        for (int i = 0; i < N; i++) exp_rdy[i] = rst && !flush && (!m_hv[i] || g == i);
        last_ready = bus.src_ready;
        check({name, " ready"}, 64'(bus.src_ready), 64'(exp_rdy));
        @(posedge clk);
        if (flush) begin
            for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
            m_cv = 1'b0;
        end else if (g >= 0) begin
            m_cv = 1'b1; m_ctag = m_tag[g]; m_cdata = m_data[g]; m_crd = m_rd[g];
            m_csrc = SW'(g); m_hv[g] = 1'b0; m_ptr = (g + 1) % N;
        end else begin
            m_cv = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (drv_valid[i] && exp_rdy[i]) begin
                m_hv[i] = 1'b1; m_tag[i] = drv_tag[i]; m_data[i] = drv_data[i]; m_rd[i] = drv_rd[i];
            end
        end
        #1;
        check({name, " cdb"},
              64'({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_rd, bus.cdb_src}),
              64'({m_cv, m_ctag, m_cdata, m_crd, m_csrc}));
    endtask

    typedef struct {
        logic [N-1:0]          valid;
        logic                  flush;
        logic [N-1:0][TW-1:0]  tags;
        logic [N-1:0]          exp_ready;
        logic                  exp_cv;
        logic [TW-1:0]         exp_tag;
        logic [SW-1:0]         exp_src;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [N-1:0] v, input logic f, input logic [N-1:0][TW-1:0] t,
                       input logic [N-1:0] r, input logic cv, input logic [TW-1:0] tg,
                       input logic [SW-1:0] s);
        vec_t e;
        e.valid = v; e.flush = f; e.tags = t; e.exp_ready = r;
        e.exp_cv = cv; e.exp_tag = tg; e.exp_src = s;
        vecs.push_back(e);
    endtask

    initial begin
        model_reset();
        drv_valid = '1;
        for (int i = 0; i < N; i++) begin
            drv_tag[i] = '0; drv_data[i] = '0; drv_rd[i] = '0;
        end
        apply_inputs();

        // Single, contention, wrap, fairness, backpressure, flush, tag/rd zero
        add(4'b0001, 0, {6'd0, 6'd0, 6'd0, 6'd5},   4'b1111, 0, 6'd0,  2'd0);
        add(4'b0000, 0, '0,                         4'b1111, 1, 6'd5,  2'd0);
        add(4'b1000, 0, {6'd9, 6'd0, 6'd0, 6'd0},   4'b1111, 0, 6'd0,  2'd0);
        add(4'b0000, 0, '0,                         4'b1111, 1, 6'd9,  2'd3);
        add(4'b1111, 0, {6'd4, 6'd3, 6'd2, 6'd1},   4'b1111, 0, 6'd0,  2'd0);
        add(4'b0000, 0, '0,                         4'b0001, 1, 6'd1,  2'd0);
        add(4'b0000, 0, '0,                         4'b0011, 1, 6'd2,  2'd1);
        add(4'b0000, 0, '0,                         4'b0111, 1, 6'd3,  2'd2);
        add(4'b0000, 0, '0,                         4'b1111, 1, 6'd4,  2'd3);
        add(4'b0000, 0, '0,                         4'b1111, 0, 6'd0,  2'd0);
        for (int k = 0; k < 5; k++) begin
            add(4'b0110, 0, {6'd0, 6'd22, 6'd11, 6'd0},
                (k == 0) ? 4'b1111 : ((k % 2 == 1) ? 4'b1011 : 4'b1101),
                (k != 0), (k == 0) ? 6'd0 : ((k % 2 == 1) ? 6'd11 : 6'd22),
                (k == 0) ? 2'd0 : ((k % 2 == 1) ? 2'd1 : 2'd2));
        end
        add(4'b0000, 0, '0,                         4'b1011, 1, 6'd11, 2'd1);
        add(4'b0000, 0, '0,                         4'b1111, 1, 6'd22, 2'd2);
        add(4'b1000, 0, {6'd7, 6'd0, 6'd0, 6'd0},   4'b1111, 0, 6'd0,  2'd0);
        add(4'b0000, 0, '0,                         4'b1111, 1, 6'd7,  2'd3);
        add(4'b1001, 0, {6'd8, 6'd0, 6'd0, 6'd6},   4'b1111, 0, 6'd0,  2'd0);
        add(4'b1000, 0, {6'd9, 6'd0, 6'd0, 6'd0},   4'b0111, 1, 6'd6,  2'd0);
        add(4'b1000, 0, {6'd9, 6'd0, 6'd0, 6'd0},   4'b1111, 1, 6'd8,  2'd3);
        add(4'b0000, 0, '0,                         4'b1111, 1, 6'd9,  2'd3);
        add(4'b0011, 0, {6'd0, 6'd0, 6'd2, 6'd0},   4'b1111, 0, 6'd0,  2'd0);
        add(4'b0011, 1, {6'd0, 6'd0, 6'd3, 6'd3},   4'b0000, 0, 6'd0,  2'd0);
        add(4'b0000, 0, '0,                         4'b1111, 0, 6'd0,  2'd0);
        add(4'b0100, 0, {6'd0, 6'd21, 6'd0, 6'd0},  4'b1111, 0, 6'd0,  2'd0);
        add(4'b0000, 0, '0,                         4'b1111, 1, 6'd21, 2'd2);
        add(4'b0000, 0, '0,                         4'b1111, 0, 6'd0,  2'd0);
        add(4'b0011, 0, {6'd0, 6'd0, 6'd2, 6'd0},   4'b1111, 0, 6'd0,  2'd0);
        add(4'b0000, 0, '0,                         4'b1101, 1, 6'd0,  2'd0);
        add(4'b0000, 0, '0,                         4'b1111, 1, 6'd2,  2'd1);
        add(4'b0000, 0, '0,                         4'b1111, 0, 6'd0,  2'd0);

        // Reset held for three clocks with every source requesting
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", 64'(bus.src_ready), 64'(4'b0000));
        check("reset cdb", 64'({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_rd, bus.cdb_src}), 64'(0));
        drv_valid = '0;
        apply_inputs();
        rst = 1'b1;
        #1;
        check("release ready", 64'(bus.src_ready), 64'(4'b1111));
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            drv_valid = vecs[k].valid;
            flush = vecs[k].flush;
            for (int i = 0; i < N; i++) begin
                drv_tag[i]  = vecs[k].tags[i];
                drv_data[i] = DW'(8'hA0) + DW'(vecs[k].tags[i]);
                drv_rd[i]   = RW'(int'(vecs[k].tags[i]) + 30);
            end
            cycle($sformatf("vec%0d", k));
            check($sformatf("vec%0d tbl_ready", k), 64'(last_ready), 64'(vecs[k].exp_ready));
            check($sformatf("vec%0d tbl_valid", k), 64'(bus.cdb_valid), 64'(vecs[k].exp_cv));
            if (vecs[k].exp_cv) begin
                check($sformatf("vec%0d tbl_tag", k), 64'(bus.cdb_tag), 64'(vecs[k].exp_tag));
                check($sformatf("vec%0d tbl_src", k), 64'(bus.cdb_src), 64'(vecs[k].exp_src));
            end
        end
        flush = 1'b0;

        // Async reset mid-broadcast: CDB drops at once and the still-held result is lost
        drv_valid = 4'b0011;
        drv_tag[0] = 6'h2A; drv_data[0] = 32'hDEAD_BEEF; drv_rd[0] = 5'd7;
        drv_tag[1] = 6'h15; drv_data[1] = 32'h1234_5678; drv_rd[1] = 5'd9;
        cycle("ar_load");
        drv_valid = '0;
        cycle("ar_grant");
        check("ar_valid_before", 64'(bus.cdb_valid), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        check("ar_async_drop", 64'({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_rd, bus.cdb_src}), 64'(0));
        check("ar_ready_low", 64'(bus.src_ready), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle("ar_idle0");
        cycle("ar_idle1");

        // Randomized traffic with occasional flushes
        for (int c = 0; c < 400; c++) begin
            drv_valid = N'($urandom);
            flush = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < N; i++) begin
                drv_tag[i]  = TW'($urandom);
                drv_data[i] = $urandom;
                drv_rd[i]   = RW'($urandom);
            end
            cycle($sformatf("rnd%0d", c));
        end
        flush = 1'b0;
        drv_valid = '0;
        repeat (N + 1) cycle("drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
